// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared encodings for the multicycle ARM-subset control unit: FSM state
//   enum, instruction op/cmd codes, datapath mux select encodings, and small
//   helpers that decode the data-processing cmd field.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  // instr[27:26]
  localparam logic [1:0] OP_DATA   = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // instr[24:21] data-processing commands
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Writeback result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Map a data-processing cmd onto the ALU; unlisted cmds fall back to ADD.
  function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Only arithmetic commands produce meaningful carry/overflow.
  function automatic logic cmd_sets_cv(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_cond_check
//   Evaluates an ARM condition field against the NZCV flags.
//   Ports:
//     cond_i     in  4  instr[31:28]
//     flags_i    in  4  NZCV
//     cond_ex_o  out 1  instruction should take effect
//   Encoding 4'b1111 is treated as never-execute.
// ---------------------------------------------------------------------------
module multicycle_ctrl_cond_check (
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      4'b0000: cond_ex_o = z;                   // EQ
      4'b0001: cond_ex_o = ~z;                  // NE
      4'b0010: cond_ex_o = c;                   // CS
      4'b0011: cond_ex_o = ~c;                  // CC
      4'b0100: cond_ex_o = n;                   // MI
      4'b0101: cond_ex_o = ~n;                  // PL
      4'b0110: cond_ex_o = v;                   // VS
      4'b0111: cond_ex_o = ~v;                  // VC
      4'b1000: cond_ex_o = c & ~z;              // HI
      4'b1001: cond_ex_o = ~c | z;              // LS
      4'b1010: cond_ex_o = (n == v);            // GE
      4'b1011: cond_ex_o = (n != v);            // LT
      4'b1100: cond_ex_o = ~z & (n == v);       // GT
      4'b1101: cond_ex_o = z | (n != v);        // LE
      4'b1110: cond_ex_o = 1'b1;                // AL
      default: cond_ex_o = 1'b0;                // 1111: never
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Sequencer for the multicycle ARM-subset core: main FSM, NZCV flag
//   register and conditional-execution gating of all side effects.
//   Ports:
//     clk_i, rst_ni                clock / async active-low reset
//     op_i, funct_i, rd_i, cond_i  instruction register fields
//     alu_flags_i                  NZCV produced by the current ALU op
//     mem_ready_i                  memory access completes this cycle
//     ir_write_o, pc_write_o       IR / PC load enables
//     adr_src_o                    memory address: 0 PC, 1 ALU result
//     mem_write_o, reg_write_o     memory / register-file write enables
//     result_src_o                 00 ALUOut, 01 ReadData, 10 ALUResult
//     alu_src_a_o, alu_src_b_o     ALU operand selects
//     alu_ctrl_o                   ALU operation
//     imm_src_o                    immediate format (op passthrough)
//     flags_o                      current NZCV register
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         ALU_CTRL_W  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            op_i,
  input  logic [5:0]            funct_i,
  input  logic [3:0]            rd_i,
  input  logic [3:0]            cond_i,
  input  logic [3:0]            alu_flags_i,
  input  logic                  mem_ready_i,
  output logic                  ir_write_o,
  output logic                  pc_write_o,
  output logic                  adr_src_o,
  output logic                  mem_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic [1:0]            imm_src_o,
  output logic [3:0]            flags_o
);

  state_e     state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_ex_q;
  logic       cond_ex;
  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] alu_op;
  logic       ir_write, pc_write, mem_write, reg_write;

  assign cmd   = funct_i[4:1];
  assign s_bit = funct_i[0];

  multicycle_ctrl_cond_check u_cond_check (
    .cond_i   (cond_i),
    .flags_i  (flags_q),
    .cond_ex_o(cond_ex)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      flags_q   <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Condition is evaluated once, against the flags as they stand when
      // the instruction is decoded.
      if (state_q == DECODE) cond_ex_q <= cond_ex;
      if ((state_q == EXECUTER || state_q == EXECUTEI) && cond_ex_q && s_bit) begin
        flags_q[3:2] <= alu_flags_i[3:2];
        if (cmd_sets_cv(cmd)) flags_q[1:0] <= alu_flags_i[1:0];
      end
    end
  end

  always_comb begin
    state_d      = FETCH;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    adr_src_o    = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    alu_op       = ALU_ADD;
    case (state_q)
      FETCH: begin
        // PC+4 computed and written back while the instruction is read.
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURESULT;
        ir_write     = mem_ready_i;
        pc_write     = mem_ready_i;
        state_d      = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        case (op_i)
          OP_MEM:    state_d = MEMADR;
          OP_DATA:   state_d = funct_i[5] ? EXECUTEI : EXECUTER;
          OP_BRANCH: state_d = BRANCH;
          default:   state_d = FETCH;
        endcase
      end
      EXECUTER: begin
        alu_op  = cmd_to_alu(cmd);
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b_o = SRCB_IMM;
        alu_op      = cmd_to_alu(cmd);
        state_d     = ALUWB;
      end
      ALUWB: begin
        // CMP only updates flags, never the register file.
        reg_write = cond_ex_q && (cmd != CMD_CMP);
        pc_write  = reg_write && (rd_i == 4'd15);
        state_d   = FETCH;
      end
      MEMADR: begin
        alu_src_b_o = SRCB_IMM;
        state_d     = funct_i[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src_o = 1'b1;
        state_d   = mem_ready_i ? MEMWB : MEMRD;
      end
      MEMWR: begin
        adr_src_o = 1'b1;
        mem_write = cond_ex_q;
        state_d   = mem_ready_i ? FETCH : MEMWR;
      end
      MEMWB: begin
        result_src_o = RES_READDATA;
        reg_write    = cond_ex_q;
        pc_write     = cond_ex_q && (rd_i == 4'd15);
        state_d      = FETCH;
      end
      BRANCH: begin
        alu_src_b_o  = SRCB_IMM;
        result_src_o = RES_ALURESULT;
        pc_write     = cond_ex_q;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset forces FETCH, whose IR/PC enables follow mem_ready_i; gating with
  // rst_ni keeps every write enable low for the whole reset interval.
  assign ir_write_o  = ir_write  & rst_ni;
  assign pc_write_o  = pc_write  & rst_ni;
  assign mem_write_o = mem_write & rst_ni;
  assign reg_write_o = reg_write & rst_ni;

  assign alu_ctrl_o = ALU_CTRL_W'(alu_op);
  assign imm_src_o  = op_i;
  assign flags_o    = flags_q;

endmodule
